trace_dumper: RTL



---
 rtl/trace_dumper_pkg.sv | 43 ++++
 rtl/trace_dumper_ser.sv | 40 ++++
 rtl/trace_dumper.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/trace_dumper_pkg.sv
// trace_dumper shared definitions.
// Register map, FSM encoding and bank helpers.
package trace_dumper_pkg;

  localparam logic [3:0] REG_CTRL  = 4'h0;
  localparam logic [3:0] REG_BANKS = 4'h4;
  localparam logic [3:0] REG_COUNT = 4'h8;
  localparam logic [3:0] REG_SENT  = 4'hC;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam int unsigned MAX_COUNT  = 1024;
  localparam int unsigned BANK_SHIFT = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_SYNC,
    ST_HDR_BANK,
    ST_REQ,
    ST_SEND,
    ST_NEXT
  } state_t;

  // {found, bank}: lowest enabled bank >= from
  function automatic logic [2:0] find_bank(
    input logic [3:0] mask,
    input logic [2:0] from
  );
    logic [2:0] r;
    r = 3'b000;
    for (int b = 3; b >= 0; b--) begin
      if (mask[b] && (3'(b) >= from))
        r = {1'b1, 2'(b)};
    end
    return r;
  endfunction

  function automatic logic [10:0] clamp_count(
    input logic [10:0] v
  );
    return (v > 11'(MAX_COUNT)) ? 11'(MAX_COUNT) : v;
  endfunction

endpackage

// File: rtl/trace_dumper_ser.sv
// trace_word_ser: 32-bit word to 4 bytes,
// MSB first, on a valid/ready port.
module trace_word_ser (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [31:0] word,
  input  logic        ready,
  output logic        valid,
  output logic [7:0]  data,
  output logic        last
);

  logic [31:0] sh;
  logic [1:0]  idx;

  assign data = sh[31:24];
  assign last = valid & ready & (idx == 2'd3);

  // shift out one byte per accepted handshake
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sh    <= 32'd0;
      idx   <= 2'd0;
      valid <= 1'b0;
    end else if (load) begin
      sh    <= word;
      idx   <= 2'd0;
      valid <= 1'b1;
    end else if (valid && ready) begin
      idx <= idx + 2'd1;
      if (idx == 2'd3)
        valid <= 1'b0;
      else
        sh <= {sh[23:0], 8'h00};
    end
  end

endmodule

// File: rtl/trace_dumper.sv
// trace_dumper: reads logger banks over a
// Wishbone master and streams framed bytes.
module trace_dumper
  import trace_dumper_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h0000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [3:2]  wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        wbs_rty_o,
  output logic [31:0] wbm_adr_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i
);

  logic [3:0]  off;
  logic        wr, start_w, abort_w;
  logic        ack_q;
  logic [3:0]  mask_q, run_mask;
  logic [10:0] count_q, run_count;
  state_t      state;
  logic [1:0]  bank;
  logic [10:0] widx, widx_nx;
  logic        busy, done, err;
  logic [12:0] sent;
  logic        cyc_q;
  logic [31:0] adr_q;
  logic        hdr_valid;
  logic [7:0]  hdr_data;
  logic [2:0]  first, nb;
  logic        ser_valid, ser_last, ser_load;
  logic [7:0]  ser_data;
  logic        unused;

  assign unused = ^{wbs_sel_i, wbs_dat_i[31:11]};

  assign off     = {wbs_adr_i, 2'b00};
  assign wr      = wbs_cyc_i & wbs_stb_i
                 & wbs_we_i & ~ack_q;
  assign abort_w = wr & (off == REG_CTRL)
                 & wbs_dat_i[1];
  assign start_w = wr & (off == REG_CTRL)
                 & wbs_dat_i[0] & ~wbs_dat_i[1];

  assign first   = find_bank(mask_q, 3'd0);
  assign nb      = find_bank(run_mask,
                             {1'b0, bank} + 3'd1);
  assign widx_nx = widx + 11'd1;

  assign ser_load = (state == ST_REQ) & wbm_ack_i
                  & ~wbm_err_i & ~abort_w;

  assign wbs_ack_o  = ack_q;
  assign wbs_err_o  = 1'b0;
  assign wbs_rty_o  = 1'b0;
  assign wbm_adr_o  = adr_q;
  assign wbm_sel_o  = 4'hf;
  assign wbm_we_o   = 1'b0;
  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = cyc_q;
  assign tx_valid_o = hdr_valid | ser_valid;
  assign tx_data_o  = hdr_valid ? hdr_data
                                : ser_data;

  function automatic logic [31:0] word_adr(
    input logic [1:0] b,
    input logic [9:0] i
  );
    return BASE_ADR
         + ({30'd0, b} << BANK_SHIFT)
         + {20'd0, i, 2'b00};
  endfunction

  // register read mux
  always_comb begin
    wbs_dat_o = 32'd0;
    unique case (1'b1)
      off == REG_CTRL:
        wbs_dat_o = {29'd0, err, done, busy};
      off == REG_BANKS:
        wbs_dat_o = {28'd0, mask_q};
      off == REG_COUNT:
        wbs_dat_o = {21'd0, count_q};
      default:
        wbs_dat_o = {19'd0, sent};
    endcase
  end

  // slave ack pulse and config registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q   <= 1'b0;
      mask_q  <= 4'hf;
      count_q <= 11'(MAX_COUNT);
    end else begin
      ack_q <= wbs_cyc_i & wbs_stb_i & ~ack_q;
      if (wr && off == REG_BANKS)
        mask_q <= wbs_dat_i[3:0];
      if (wr && off == REG_COUNT)
        count_q <= clamp_count(wbs_dat_i[10:0]);
    end
  end

  // dump sequencer, bus master and status
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      bank      <= 2'd0;
      widx      <= 11'd0;
      run_mask  <= 4'd0;
      run_count <= 11'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      sent      <= 13'd0;
      cyc_q     <= 1'b0;
      adr_q     <= 32'd0;
      hdr_valid <= 1'b0;
      hdr_data  <= 8'd0;
    end else if (abort_w) begin
      if (ser_last)
        sent <= sent + 13'd1;
      state     <= ST_IDLE;
      cyc_q     <= 1'b0;
      hdr_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (ser_last)
        sent <= sent + 13'd1;
      unique case (state)
        ST_IDLE: begin
          if (start_w) begin
            done      <= 1'b0;
            err       <= 1'b0;
            sent      <= 13'd0;
            busy      <= 1'b1;
            run_mask  <= mask_q;
            run_count <= count_q;
            widx      <= 11'd0;
            if (first[2] && count_q != 11'd0) begin
              bank      <= first[1:0];
              hdr_valid <= 1'b1;
              hdr_data  <= SYNC_BYTE;
              state     <= ST_HDR_SYNC;
            end else begin
              bank  <= 2'd0;
              state <= ST_NEXT;
            end
          end
        end
        ST_HDR_SYNC: begin
          if (tx_ready_i) begin
            hdr_data <= {6'd0, bank};
            state    <= ST_HDR_BANK;
          end
        end
        ST_HDR_BANK: begin
          if (tx_ready_i) begin
            hdr_valid <= 1'b0;
            cyc_q     <= 1'b1;
            adr_q     <= word_adr(bank, widx[9:0]);
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (wbm_err_i) begin
            cyc_q <= 1'b0;
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (wbm_ack_i) begin
            cyc_q <= 1'b0;
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (ser_last) begin
            if (widx_nx < run_count) begin
              widx  <= widx_nx;
              cyc_q <= 1'b1;
              adr_q <= word_adr(bank, widx_nx[9:0]);
              state <= ST_REQ;
            end else begin
              state <= ST_NEXT;
            end
          end
        end
        ST_NEXT: begin
          if (nb[2] && run_count != 11'd0) begin
            bank      <= nb[1:0];
            widx      <= 11'd0;
            hdr_valid <= 1'b1;
            hdr_data  <= SYNC_BYTE;
            state     <= ST_HDR_SYNC;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  trace_word_ser u_ser (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .clr   (abort_w),
    .load  (ser_load),
    .word  (wbm_dat_i),
    .ready (tx_ready_i),
    .valid (ser_valid),
    .data  (ser_data),
    .last  (ser_last)
  );

endmodule
